// File: rtl/random_delay_counter_pkg.sv
// Shared constants for the reaction-game random delay counter.
// State encoding, LFSR taps and the common datapath width.
package random_delay_counter_pkg;

    localparam int DATA_W = 13;
    localparam int LFSR_W = 16;

    // x^16 + x^14 + x^13 + x^11 + 1 -> bits 15, 13, 12, 10
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/random_delay_counter_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR with recovery from the all-zero
// lock-up state.
module lfsr16
    import random_delay_counter_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
    input  logic              Clock,
    input  logic              CLRN,
    output logic [LFSR_W-1:0] q
);

    logic [LFSR_W-1:0] q_q;
    logic [LFSR_W-1:0] q_d;

    always_comb begin
        q_d = {q_q[LFSR_W-2:0], ^(q_q & LFSR_TAPS)};
        if (q_q == '0) begin
            q_d = SEED;
        end
    end

    always_ff @(posedge Clock or negedge CLRN) begin
        if (!CLRN) begin
            q_q <= SEED;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/random_delay_counter.sv
// Random wait generator: latches MIN + random ms on start, counts it out
// with a prescaler and holds done until enable is withdrawn.
module random_delay_counter
    import random_delay_counter_pkg::*;
#(
    parameter int          CLK_PER_MS   = 50000,
    parameter int          MIN_DELAY_MS = 1000,
    parameter int          RANGE_BITS   = 11,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic              Clock,
    input  logic              CLRN,
    input  logic              enable,
    input  logic              clear,
    output logic              done,
    output logic              busy,
    output logic [DATA_W-1:0] delay_ms
);

    localparam int PRE_W = $clog2(CLK_PER_MS);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_PER_MS - 1);

    if ((MIN_DELAY_MS + (2 ** RANGE_BITS) - 1) > 8191 ||
        MIN_DELAY_MS < 1 || CLK_PER_MS < 2 ||
        LFSR_SEED == 16'h0000) begin : g_bad_params
        $error("random_delay_counter: illegal parameter set");
    end

    logic [LFSR_W-1:0] lfsr_q;
    logic              lfsr_unused;
    logic [DATA_W-1:0] target;

    lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .Clock (Clock),
        .CLRN  (CLRN),
        .q     (lfsr_q)
    );

    assign lfsr_unused = ^lfsr_q[LFSR_W-1:RANGE_BITS];
    assign target = DATA_W'(MIN_DELAY_MS)
                  + DATA_W'(lfsr_q[RANGE_BITS-1:0]);

    state_e            state_q, state_d;
    logic [PRE_W-1:0]  pre_q, pre_d;
    logic [DATA_W-1:0] ms_q, ms_d;
    logic [DATA_W-1:0] delay_q, delay_d;

    always_comb begin
        state_d = state_q;
        pre_d   = pre_q;
        ms_d    = ms_q;
        delay_d = delay_q;
        if (clear) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (enable) begin
                        state_d = COUNT;
                        delay_d = target;
                        pre_d   = '0;
                        ms_d    = '0;
                    end
                end
                COUNT: begin
                    if (!enable) begin
                        state_d = IDLE;
                    end else if (pre_q == PRE_LAST) begin
                        pre_d = '0;
                        // ms stops at delay-1 on the final tick
                        if (ms_q == delay_q - DATA_W'(1)) begin
                            state_d = DONE;
                        end else begin
                            ms_d = ms_q + DATA_W'(1);
                        end
                    end else begin
                        pre_d = pre_q + PRE_W'(1);
                    end
                end
                DONE: begin
                    if (!enable) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge Clock or negedge CLRN) begin
        if (!CLRN) begin
            state_q <= IDLE;
            pre_q   <= '0;
            ms_q    <= '0;
            delay_q <= '0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            ms_q    <= ms_d;
            delay_q <= delay_d;
        end
    end

    assign done     = (state_q == DONE);
    assign busy     = (state_q == COUNT);
    assign delay_ms = delay_q;

endmodule
